// File: rtl/alu_acc_sequencer_if.sv
// Command and response handshake channels between a command source and the
// accumulator sequencer.
interface alu_acc_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_imm;
    logic             rsp_valid;
    logic             rsp_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid
    );
endinterface

// File: rtl/alu_acc_sequencer.sv
// Accumulator machine around an external combinational or registered ALU: one command
// in flight, operands held for EXEC_CYCLES, result and flags captured, response handshake.
module alu_acc_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    alu_acc_sequencer_if.slave io_bus,
    output logic [WIDTH-1:0]   o_alu_a,
    output logic [WIDTH-1:0]   o_alu_b,
    output logic [2:0]         o_alu_op,
    input  logic [WIDTH-1:0]   i_alu_result,
    input  logic               i_alu_c,
    input  logic               i_alu_z,
    input  logic               i_alu_v,
    input  logic               i_alu_n,
    output logic [WIDTH-1:0]   o_acc,
    output logic [3:0]         o_flags,
    output logic [CNT_W-1:0]   o_op_count
);

    localparam int unsigned EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [EW-1:0] ExecLast = EW'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           r_state,    w_state;
    logic [WIDTH-1:0] r_acc,      w_acc;
    logic [3:0]       r_flags,    w_flags;
    logic [CNT_W-1:0] r_op_count, w_op_count;
    logic [WIDTH-1:0] r_imm,      w_imm;
    logic [2:0]       r_op,       w_op;
    logic             r_load,     w_load;
    logic [EW-1:0]    r_exec_cnt, w_exec_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_flags    <= '0;
            r_op_count <= '0;
            r_imm      <= '0;
            r_op       <= '0;
            r_load     <= 1'b0;
            r_exec_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_acc      <= w_acc;
            r_flags    <= w_flags;
            r_op_count <= w_op_count;
            r_imm      <= w_imm;
            r_op       <= w_op;
            r_load     <= w_load;
            r_exec_cnt <= w_exec_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_acc      = r_acc;
        w_flags    = r_flags;
        w_op_count = r_op_count;
        w_imm      = r_imm;
        w_op       = r_op;
        w_load     = r_load;
        w_exec_cnt = r_exec_cnt;

        unique case (r_state)
            StIdle: begin
                if (io_bus.cmd_valid) begin
                    w_op       = io_bus.cmd_op;
                    w_imm      = io_bus.cmd_imm;
                    w_load     = io_bus.cmd_load;
                    w_exec_cnt = '0;
                    w_state    = StExec;
                end
            end
            StExec: begin
                if (r_exec_cnt == ExecLast) begin
                    if (r_load) begin
                        // Loads bypass the ALU, so flags are derived from the immediate here.
                        w_acc   = r_imm;
                        w_flags = {1'b0, (r_imm == '0), 1'b0, r_imm[WIDTH-1]};
                    end else begin
                        w_acc   = i_alu_result;
                        w_flags = {i_alu_c, i_alu_z, i_alu_v, i_alu_n};
                    end
                    w_state = StResp;
                end else begin
                    w_exec_cnt = r_exec_cnt + 1'b1;
                end
            end
            StResp: begin
                if (io_bus.rsp_ready) begin
                    w_op_count = r_op_count + 1'b1;
                    w_state    = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign io_bus.cmd_ready = (r_state == StIdle);
    assign io_bus.rsp_valid = (r_state == StResp);

    assign o_alu_a    = r_acc;
    assign o_alu_b    = r_imm;
    assign o_alu_op   = r_op;
    assign o_acc      = r_acc;
    assign o_flags    = r_flags;
    assign o_op_count = r_op_count;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench for alu_acc_sequencer with a behavioural 8-bit ALU; a second instance
// uses a 2-bit counter and a 3-cycle execute phase.
module tb_alu_acc_sequencer;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    int exp_cnt_a;
    int exp_cnt_b;

    alu_acc_sequencer_if #(.WIDTH(8)) bus_a ();
    alu_acc_sequencer_if #(.WIDTH(8)) bus_b ();

    logic [7:0] alu_a_a, alu_b_a, res_a, acc_a;
    logic [2:0] alu_op_a;
    logic       c_a, z_a, v_a, n_a;
    logic [3:0] flags_a;
    logic [7:0] cnt_a;

    logic [7:0] alu_a_b, alu_b_b, res_b, acc_b;
    logic [2:0] alu_op_b;
    logic       c_b, z_b, v_b, n_b;
    logic [3:0] flags_b;
    logic [1:0] cnt_b;

    // Returns {result, c, z, v, n}; SUB carry is no-borrow.
    function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'b001: begin
                r = a - b;
                c = (a >= b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = ~a;
            3'b110: begin
                r = {a[6:0], 1'b0};
                c = a[7];
            end
            default: begin
                r = {1'b0, a[7:1]};
                c = a[0];
            end
        endcase
        return {r, c, (r == 8'h00), v, r[7]};
    endfunction

    assign {res_a, c_a, z_a, v_a, n_a} = alu_model(alu_op_a, alu_a_a, alu_b_a);
    assign {res_b, c_b, z_b, v_b, n_b} = alu_model(alu_op_b, alu_a_b, alu_b_b);

    alu_acc_sequencer #(.WIDTH(8), .CNT_W(8), .EXEC_CYCLES(1)) u_dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .io_bus       (bus_a.slave),
        .o_alu_a      (alu_a_a),
        .o_alu_b      (alu_b_a),
        .o_alu_op     (alu_op_a),
        .i_alu_result (res_a),
        .i_alu_c      (c_a),
        .i_alu_z      (z_a),
        .i_alu_v      (v_a),
        .i_alu_n      (n_a),
        .o_acc        (acc_a),
        .o_flags      (flags_a),
        .o_op_count   (cnt_a)
    );

    alu_acc_sequencer #(.WIDTH(8), .CNT_W(2), .EXEC_CYCLES(3)) u_dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .io_bus       (bus_b.slave),
        .o_alu_a      (alu_a_b),
        .o_alu_b      (alu_b_b),
        .o_alu_op     (alu_op_b),
        .i_alu_result (res_b),
        .i_alu_c      (c_b),
        .i_alu_z      (z_b),
        .i_alu_v      (v_b),
        .i_alu_n      (n_b),
        .o_acc        (acc_b),
        .o_flags      (flags_b),
        .o_op_count   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Issue one command to instance A and check latency, held operands and captured state.
    task automatic a_cmd(input logic ld, input logic [2:0] op, input logic [7:0] imm,
                         input logic [7:0] exp_acc, input logic [3:0] exp_flags,
                         input string name);
        int         n;
        logic [7:0] acc_before;
        acc_before      = acc_a;
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_load  = ld;
        bus_a.cmd_op    = op;
        bus_a.cmd_imm   = imm;
        n = 0;
        while (bus_a.cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL %s accept: cmd_ready=%b, required 1", name, bus_a.cmd_ready);
        end
        @(posedge clk); #1;
        bus_a.cmd_valid = 1'b0;
        n_checks++;
        if ({bus_a.rsp_valid, bus_a.cmd_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s exec_hs: rsp_valid/cmd_ready=%b%b, required 00", name,
                     bus_a.rsp_valid, bus_a.cmd_ready);
        end
        n_checks++;
        if (alu_a_a !== acc_before || alu_b_a !== imm || alu_op_a !== op) begin
            n_fail++;
            $display("FAIL %s operands: a=%h b=%h op=%b, required a=%h b=%h op=%b", name,
                     alu_a_a, alu_b_a, alu_op_a, acc_before, imm, op);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus_a.rsp_valid !== 1'b1 || acc_a !== exp_acc || flags_a !== exp_flags) begin
            n_fail++;
            $display("FAIL %s result: rsp_valid=%b acc=%h flags=%b, required 1 %h %b", name,
                     bus_a.rsp_valid, acc_a, flags_a, exp_acc, exp_flags);
        end
        if (bus_a.rsp_ready) begin
            @(posedge clk); #1;
            exp_cnt_a++;
            n_checks++;
            if (cnt_a !== 8'(exp_cnt_a) || bus_a.cmd_ready !== 1'b1 || bus_a.rsp_valid !== 1'b0)
            begin
                n_fail++;
                $display("FAIL %s done: op_count=%0d cmd_ready=%b rsp_valid=%b, required %0d 1 0",
                         name, cnt_a, bus_a.cmd_ready, bus_a.rsp_valid, exp_cnt_a);
            end
        end
    endtask

    // Issue one command to instance B (3 execute cycles, 2-bit counter).
    task automatic b_cmd(input logic ld, input logic [2:0] op, input logic [7:0] imm,
                         input logic [7:0] exp_acc, input string name);
        int n;
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_load  = ld;
        bus_b.cmd_op    = op;
        bus_b.cmd_imm   = imm;
        n = 0;
        while (bus_b.cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus_b.cmd_valid = 1'b0;
        n = 0;
        while (bus_b.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n != 3 || acc_b !== exp_acc) begin
            n_fail++;
            $display("FAIL %s latency: cycles=%0d acc=%h, required 3 %h", name, n, acc_b, exp_acc);
        end
        @(posedge clk); #1;
        exp_cnt_b++;
        n_checks++;
        if (cnt_b !== 2'(exp_cnt_b)) begin
            n_fail++;
            $display("FAIL %s count: op_count=%0d, required %0d", name, cnt_b, exp_cnt_b % 4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        n_checks++;
        if (acc_a !== 8'h00 || flags_a !== 4'b0000 || cnt_a !== 8'h00 ||
            bus_a.rsp_valid !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_a: acc=%h flags=%b cnt=%0d rsp_valid=%b cmd_ready=%b, required 00 0000 0 0 1",
                     acc_a, flags_a, cnt_a, bus_a.rsp_valid, bus_a.cmd_ready);
        end
        n_checks++;
        if (acc_b !== 8'h00 || cnt_b !== 2'b00 || bus_b.cmd_ready !== 1'b1 ||
            alu_b_a !== 8'h00 || alu_op_a !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_b: acc=%h cnt=%0d cmd_ready=%b alu_b=%h alu_op=%b, required 00 0 1 00 000",
                     acc_b, cnt_b, bus_b.cmd_ready, alu_b_a, alu_op_a);
        end
    endtask

    task automatic test_load_add();
        a_cmd(1'b1, 3'b000, 8'd10, 8'd10, 4'b0000, "load10");
        a_cmd(1'b0, 3'b000, 8'd5,  8'd15, 4'b0000, "add5");
        n_checks++;
        if (cnt_a !== 8'd2) begin
            n_fail++;
            $display("FAIL load_add_count: op_count=%0d, required 2", cnt_a);
        end
    endtask

    task automatic test_add_overflow();
        a_cmd(1'b1, 3'b000, 8'd127, 8'h7F, 4'b0000, "load127");
        a_cmd(1'b0, 3'b000, 8'd1,   8'h80, 4'b0011, "add1_ovf");
        a_cmd(1'b1, 3'b000, 8'd200, 8'hC8, 4'b0001, "load200");
        a_cmd(1'b0, 3'b000, 8'd100, 8'd44, 4'b1000, "add100_carry");
    endtask

    task automatic test_sub();
        a_cmd(1'b1, 3'b000, 8'd20, 8'd20,  4'b0000, "load20");
        a_cmd(1'b0, 3'b001, 8'd50, 8'hE2,  4'b0001, "sub50_borrow");
        a_cmd(1'b1, 3'b000, 8'd5,  8'd5,   4'b0000, "load5");
        a_cmd(1'b0, 3'b001, 8'd5,  8'h00,  4'b1100, "sub5_zero");
    endtask

    task automatic test_logic_shift();
        a_cmd(1'b1, 3'b111, 8'hF0, 8'hF0, 4'b0001, "load_f0");
        a_cmd(1'b0, 3'b100, 8'hFF, 8'h0F, 4'b0000, "xor_ff");
        a_cmd(1'b1, 3'b000, 8'h81, 8'h81, 4'b0001, "load_81");
        a_cmd(1'b0, 3'b110, 8'h00, 8'h02, 4'b1000, "sll");
        a_cmd(1'b1, 3'b000, 8'h00, 8'h00, 4'b0100, "load_zero");
        a_cmd(1'b0, 3'b101, 8'h3C, 8'hFF, 4'b0001, "not");
    endtask

    task automatic test_backpressure();
        bus_a.rsp_ready = 1'b0;
        a_cmd(1'b1, 3'b000, 8'h33, 8'h33, 4'b0000, "bp_load33");
        for (int i = 0; i < 5; i++) begin
            bus_a.cmd_valid = i[0] ? 1'b0 : 1'b1;
            bus_a.cmd_load  = 1'b1;
            bus_a.cmd_imm   = 8'hFF;
            @(posedge clk); #1;
            n_checks++;
            if (bus_a.rsp_valid !== 1'b1 || bus_a.cmd_ready !== 1'b0 || acc_a !== 8'h33 ||
                flags_a !== 4'b0000 || cnt_a !== 8'(exp_cnt_a)) begin
                n_fail++;
                $display("FAIL bp_hold%0d: rsp_valid=%b cmd_ready=%b acc=%h flags=%b cnt=%0d, required 1 0 33 0000 %0d",
                         i, bus_a.rsp_valid, bus_a.cmd_ready, acc_a, flags_a, cnt_a, exp_cnt_a);
            end
        end
        bus_a.cmd_valid = 1'b0;
        bus_a.rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt_a++;
        n_checks++;
        if (cnt_a !== 8'(exp_cnt_a) || bus_a.cmd_ready !== 1'b1 || bus_a.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: cnt=%0d cmd_ready=%b rsp_valid=%b, required %0d 1 0",
                     cnt_a, bus_a.cmd_ready, bus_a.rsp_valid, exp_cnt_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (acc_a !== 8'h33 || bus_a.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_accept: acc=%h cmd_ready=%b, required 33 1", acc_a, bus_a.cmd_ready);
        end
    endtask

    task automatic test_reset_in_exec();
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_load  = 1'b1;
        bus_a.cmd_imm   = 8'h77;
        @(posedge clk); #1;
        bus_a.cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        n_checks++;
        if (acc_a !== 8'h00 || flags_a !== 4'b0000 || cnt_a !== 8'h00 ||
            bus_a.rsp_valid !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec: acc=%h flags=%b cnt=%0d rsp_valid=%b cmd_ready=%b, required 00 0000 0 0 1",
                     acc_a, flags_a, cnt_a, bus_a.rsp_valid, bus_a.cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus_a.rsp_valid !== 1'b0 || acc_a !== 8'h00 || cnt_a !== 8'h00) begin
                n_fail++;
                $display("FAIL rst_exec_quiet%0d: rsp_valid=%b acc=%h cnt=%0d, required 0 00 0",
                         i, bus_a.rsp_valid, acc_a, cnt_a);
            end
        end
    endtask

    task automatic test_count_wrap();
        b_cmd(1'b1, 3'b000, 8'd9,  8'd9,  "b_load9");
        b_cmd(1'b0, 3'b000, 8'd7,  8'd16, "b_add7");
        b_cmd(1'b0, 3'b001, 8'd16, 8'd0,  "b_sub16");
        b_cmd(1'b1, 3'b000, 8'hAA, 8'hAA, "b_load_aa");
        n_checks++;
        if (cnt_b !== 2'b00 || flags_b !== 4'b0001) begin
            n_fail++;
            $display("FAIL count_wrap: op_count=%0d flags=%b, required 0 0001", cnt_b, flags_b);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        exp_cnt_a       = 0;
        exp_cnt_b       = 0;
        rst             = 1'b1;
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_op    = 3'b000;
        bus_a.cmd_load  = 1'b0;
        bus_a.cmd_imm   = 8'h00;
        bus_a.rsp_ready = 1'b1;
        bus_b.cmd_valid = 1'b0;
        bus_b.cmd_op    = 3'b000;
        bus_b.cmd_load  = 1'b0;
        bus_b.cmd_imm   = 8'h00;
        bus_b.rsp_ready = 1'b1;

        test_reset();
        test_load_add();
        test_add_overflow();
        test_sub();
        test_logic_shift();
        test_backpressure();
        test_reset_in_exec();
        test_count_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
